mac_readout: RTL and testbench

- Output-side controller for the conventional MAC wrapper.
- Paces operand windows, drives the wrapper's accu_rst at the start of each window, and captures the accumulator z once the last product of a window has propagated.
- Delivers each captured result downstream over a valid/ready stream through a small FIFO.
- Sits between the MAC wrapper's z output and the result writeback path.

---
 rtl/mac_readout.sv | 191 +++++++++++++++++++
 tb/tb_mac_readout.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_readout.sv
`default_nettype none
// ============================================================================
// Module   : mac_readout
// Purpose  : Output-side controller for the MAC wrapper. Paces operand
//            windows, pulses accu_rst on the first operand of each window,
//            captures z once the window's last product has landed and
//            streams the captured results out through a small FWFT FIFO.
// Options  : MAC_READOUT_RELU_EN - negative captures are stored as zero.
// Revision : 1.0 - initial release
// ============================================================================
module mac_readout #(
    parameter int Z_WIDTH    = 20,
    parameter int ACC_LEN    = 16,
    parameter int MAC_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [15:0]        num_out,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               accu_rst,
    input  logic [Z_WIDTH-1:0] z,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Z_WIDTH-1:0] out_data,
    output logic               busy,
    output logic               done,
    output logic               overflow
);

    localparam int              c_ew        = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam int              c_pw        = $clog2(FIFO_DEPTH);
    localparam logic [c_ew-1:0] c_elem_last = c_ew'(ACC_LEN - 1);
    localparam logic [c_pw:0]   c_fifo_full = (c_pw + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [15:0]        r_num;
    logic [15:0]        r_win_cnt;
    logic [c_ew-1:0]    r_elem_cnt;
    logic [MAC_LAT-1:0] r_dl;
    logic [Z_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_pw-1:0]    r_wr_ptr;
    logic [c_pw-1:0]    r_rd_ptr;
    logic [c_pw:0]      r_count;
    logic               r_overflow;

    logic               w_accept;
    logic               w_win_last;
    logic               w_run_last;
    logic               w_start_ok;
    logic               w_cap;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic               w_dl_empty;
    logic [Z_WIDTH-1:0] w_cap_data;

    assign w_accept   = (r_state == S_RUN) & in_valid;
    assign w_win_last = w_accept & (r_elem_cnt == c_elem_last);
    assign w_run_last = w_win_last & (r_win_cnt == (r_num - 16'd1));
    assign w_start_ok = (r_state == S_IDLE) & start;
    // A token leaving the last stage means z now includes the window's last product
    assign w_cap      = r_dl[MAC_LAT-1];
    assign w_dl_empty = ~|r_dl;
    assign w_full     = (r_count == c_fifo_full);
    assign w_pop      = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign w_push     = w_cap & (~w_full | w_pop);
    assign w_drop     = w_cap & w_full & ~w_pop;

`ifdef MAC_READOUT_RELU_EN
    assign w_cap_data = z[Z_WIDTH-1] ? '0 : z;
`else
    assign w_cap_data = z;
`endif

    assign accu_rst  = w_accept & (r_elem_cnt == '0);
    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_rd_ptr];
    assign overflow  = r_overflow;

    // Run length latch plus element/window counters over accepted operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num      <= '0;
            r_win_cnt  <= '0;
            r_elem_cnt <= '0;
        end else if (w_start_ok) begin
            r_num      <= num_out;
            r_win_cnt  <= '0;
            r_elem_cnt <= '0;
        end else if (w_accept) begin
            if (w_win_last) begin
                r_elem_cnt <= '0;
                r_win_cnt  <= r_win_cnt + 16'd1;
            end else begin
                r_elem_cnt <= r_elem_cnt + c_ew'(1);
            end
        end
    end

    // Window-closing tokens travel alongside the MAC pipeline
    generate
        if (MAC_LAT == 1) begin : g_dl_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_dl <= '0;
                else        r_dl <= w_win_last;
            end
        end else begin : g_dl_multi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_dl <= '0;
                else        r_dl <= {r_dl[MAC_LAT-2:0], w_win_last};
            end
        end
    endgenerate

    // Sticky drop flag, cleared when a new run is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_overflow <= 1'b0;
        else if (w_start_ok) r_overflow <= 1'b0;
        else if (w_drop)     r_overflow <= 1'b1;
    end

    // Result FIFO storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_cap_data;
                r_wr_ptr        <= r_wr_ptr + c_pw'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + c_pw'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_pw + 1)'(1);
                2'b01:   r_count <= r_count - (c_pw + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = (num_out != 16'd0) ? S_RUN : S_DONE;
            end
            S_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_run_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (w_dl_empty && (r_count == '0)) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_readout.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_readout
// Purpose  : Self-checking bench for mac_readout with a behavioural
//            two-stage MAC wrapper model feeding z.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_readout;

    localparam int ZW    = 20;
    localparam int ACC   = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [15:0]       num_out;
    logic              in_valid;
    logic              in_ready;
    logic              accu_rst;
    logic [ZW-1:0]     z;
    logic              out_valid;
    logic              out_ready;
    logic [ZW-1:0]     out_data;
    logic              busy;
    logic              done;
    logic              overflow;
    logic signed [7:0] w_op;
    logic signed [7:0] a_op;

    mac_readout #(
        .Z_WIDTH    (ZW),
        .ACC_LEN    (ACC),
        .MAC_LAT    (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_out   (num_out),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .accu_rst  (accu_rst),
        .z         (z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // MAC wrapper model: operands and accu_rst registered, then accumulated
    logic signed [ZW-1:0] m_prod;
    logic signed [ZW-1:0] m_z;
    logic                 m_rst;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prod <= '0;
            m_rst  <= 1'b0;
            m_z    <= '0;
        end else begin
            if (in_valid && in_ready) m_prod <= ZW'(w_op) * ZW'(a_op);
            else                      m_prod <= '0;
            m_rst <= accu_rst;
            m_z   <= m_rst ? m_prod : m_z + m_prod;
        end
    end
    assign z = m_z;

    typedef struct {
        int            num;
        int            w;
        int            a;
        int            gap_at;
        int            gap_len;
        logic [ZW-1:0] res;
    } vec_t;

    vec_t          vecs [5];
    logic [ZW-1:0] q_exp [$];
    int            n_total = 0;
    int            n_pass  = 0;
    int            cyc_no  = 0;
    int            first_ov;
    int            first_ovf;
    int            done_cnt;
    int            n_pop;
    int            t_last;
    int            t_w0;
    int            t_w4;
    bit            prev_hold = 1'b0;
    logic [ZW-1:0] prev_data;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    endtask

    function automatic logic [ZW-1:0] expv(input int w, input int a);
        int s;
        s = w * a * ACC;
`ifdef MAC_READOUT_RELU_EN
        if (s < 0) s = 0;
`endif
        return ZW'(s);
    endfunction

    task automatic set_vec(input int i, input int num, input int w, input int a,
                           input int gap_at, input int gap_len, input logic [ZW-1:0] res);
        vecs[i].num     = num;
        vecs[i].w       = w;
        vecs[i].a       = a;
        vecs[i].gap_at  = gap_at;
        vecs[i].gap_len = gap_len;
        vecs[i].res     = res;
    endtask

    // Mid-cycle observation: scoreboard pops, head stability, event stamps
    task automatic sample();
        if (!rst_n) begin
            prev_hold = 1'b0;
            return;
        end
        if (prev_hold) begin
            check("head_stable_valid", out_valid, 1);
            check("head_stable_data", out_data, prev_data);
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
        if (out_valid && out_ready) begin
            n_pop++;
            if (q_exp.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_result: got %0h, expected no output", out_data);
            end else begin
                check("result", out_data, q_exp.pop_front());
            end
        end
        if (out_valid && first_ov < 0) first_ov = cyc_no;
        if (overflow && first_ovf < 0) first_ovf = cyc_no;
        if (done) done_cnt++;
    endtask

    task automatic half_neg();
        @(negedge clk);
        sample();
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic cyc();
        half_neg();
        to_pos();
    endtask

    task automatic do_start(input int n);
        first_ov  = -1;
        first_ovf = -1;
        done_cnt  = 0;
        n_pop     = 0;
        start     = 1'b1;
        num_out   = 16'(n);
        cyc();
        start     = 1'b0;
        num_out   = '0;
    endtask

    task automatic drive_window(input int w, input int a, input int gap_at, input int gap_len,
                                input logic [ZW-1:0] res, input bit push);
        for (int e = 0; e < ACC; e++) begin
            if (e == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    in_valid = 1'b0;
                    w_op     = '0;
                    a_op     = '0;
                    half_neg();
                    check("gap_accu_rst", accu_rst, 0);
                    to_pos();
                end
            end
            in_valid = 1'b1;
            w_op     = 8'(w);
            a_op     = 8'(a);
            half_neg();
            check("accu_rst", accu_rst, (e == 0));
            if (e == ACC - 1) begin
                t_last = cyc_no;
                if (push) q_exp.push_back(res);
            end
            to_pos();
        end
        in_valid = 1'b0;
        w_op     = '0;
        a_op     = '0;
    endtask

    task automatic wait_done(input int bound);
        int k;
        k = 0;
        half_neg();
        while (done_cnt == 0 && k < bound) begin
            to_pos();
            half_neg();
            k++;
        end
        check("done_seen", (done_cnt != 0), 1);
        to_pos();
        half_neg();
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        to_pos();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        set_vec(0, 1, 3, 2, -1, 0, 20'd24);
        set_vec(1, 2, 3, 2, 1, 3, 20'd24);
`ifdef MAC_READOUT_RELU_EN
        set_vec(2, 2, -3, 2, -1, 0, 20'd0);
`else
        set_vec(2, 2, -3, 2, -1, 0, ZW'(-24));
`endif
        set_vec(3, 1, 100, 100, -1, 0, 20'd40000);
        set_vec(4, 2, -128, -128, -1, 0, 20'd65536);

        // Reset state
        rst_n     = 1'b0;
        start     = 1'b0;
        num_out   = '0;
        in_valid  = 1'b0;
        w_op      = '0;
        a_op      = '0;
        out_ready = 1'b0;
        first_ov  = -1;
        first_ovf = -1;
        done_cnt  = 0;
        n_pop     = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        to_pos();

        // in_valid while idle produces nothing
        in_valid = 1'b1;
        w_op     = 8'sd5;
        a_op     = 8'sd5;
        half_neg();
        check("idle_accu_rst", accu_rst, 0);
        check("idle_in_ready", in_ready, 0);
        to_pos();
        in_valid = 1'b0;
        w_op     = '0;
        a_op     = '0;
        repeat (3) cyc();

        // Table-driven runs
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b1;
            do_start(vecs[i].num);
            check("busy_in_run", busy, 1);
            for (int k = 0; k < vecs[i].num; k++) begin
                drive_window(vecs[i].w, vecs[i].a, (k == 0) ? vecs[i].gap_at : -1,
                             vecs[i].gap_len, vecs[i].res, 1'b1);
                if (k == 0) t_w0 = t_last;
            end
            wait_done(100);
            check("capture_latency", first_ov - t_w0, LAT + 1);
            check("queue_empty", q_exp.size(), 0);
            check("pop_count", n_pop, vecs[i].num);
        end

        // Backpressure with overflow: only the first DEPTH captures survive
        out_ready = 1'b0;
        do_start(6);
        for (int k = 0; k < 6; k++) begin
            drive_window(k + 1, 1, -1, 0, expv(k + 1, 1), (k < DEPTH));
            if (k == DEPTH) t_w4 = t_last;
        end
        repeat (4) cyc();
        check("ovf_set", overflow, 1);
        check("ovf_timing", first_ovf - t_w4, LAT + 1);
        check("ovf_head_valid", out_valid, 1);
        check("ovf_head_data", out_data, expv(1, 1));
        out_ready = 1'b1;
        wait_done(100);
        check("ovf_queue_empty", q_exp.size(), 0);
        check("ovf_pop_count", n_pop, DEPTH);
        check("ovf_sticky", overflow, 1);

        // Full FIFO with pop on the capture edge: nothing dropped
        out_ready = 1'b0;
        do_start(5);
        check("ovf_cleared_on_start", overflow, 0);
        for (int k = 0; k < 5; k++) begin
            drive_window(k + 2, 1, -1, 0, expv(k + 2, 1), 1'b1);
        end
        half_neg();
        to_pos();
        out_ready = 1'b1;
        half_neg();
        to_pos();
        out_ready = 1'b0;
        half_neg();
        check("pushpop_no_overflow", overflow, 0);
        check("pushpop_valid", out_valid, 1);
        to_pos();
        out_ready = 1'b1;
        wait_done(100);
        check("pushpop_queue_empty", q_exp.size(), 0);
        check("pushpop_pop_count", n_pop, 5);
        check("pushpop_no_overflow_end", overflow, 0);

        // Asynchronous reset in the middle of a run
        out_ready = 1'b0;
        do_start(3);
        drive_window(1, 1, -1, 0, expv(1, 1), 1'b1);
        cyc();
        cyc();
        in_valid = 1'b1;
        w_op     = 8'sd1;
        a_op     = 8'sd1;
        #1;
        check("pre_rst_busy", busy, 1);
        check("pre_rst_out_valid", out_valid, 1);
        check("pre_rst_accu_rst", accu_rst, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_accu_rst", accu_rst, 0);
        check("async_rst_out_data", out_data, 0);
        q_exp.delete();
        prev_hold = 1'b0;
        in_valid  = 1'b0;
        w_op      = '0;
        a_op      = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        half_neg();
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_busy", busy, 0);
        to_pos();

        // start while busy is ignored
        out_ready = 1'b1;
        do_start(1);
        start   = 1'b1;
        num_out = 16'd5;
        cyc();
        start   = 1'b0;
        num_out = '0;
        drive_window(2, 2, -1, 0, expv(2, 2), 1'b1);
        wait_done(60);
        check("busy_start_pop_count", n_pop, 1);
        check("busy_start_queue_empty", q_exp.size(), 0);

        // start with num_out == 0
        n_pop   = 0;
        start   = 1'b1;
        num_out = '0;
        half_neg();
        check("zero_start_no_done_yet", done, 0);
        to_pos();
        start = 1'b0;
        half_neg();
        check("zero_start_done", done, 1);
        check("zero_start_busy", busy, 0);
        to_pos();
        half_neg();
        check("zero_start_done_cleared", done, 0);
        check("zero_start_no_output", out_valid, 0);
        to_pos();
        check("zero_start_pop_count", n_pop, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
